// File: rtl/majority_window_filter.sv
// Multi-channel sliding-window majority voter with hysteresis.
// Each channel counts ones in its last WIN accepted samples.
module majority_window_filter #(
  parameter int CH  = 4,
  parameter int WIN = 5,
  parameter int HI  = (WIN + 1) / 2,
  parameter int LO  = (WIN - 1) / 2,
  localparam int CW = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CH-1:0]    inp,
  input  logic             clear,
  output logic [CH-1:0]    out,
  output logic             out_valid,
  output logic [CH*CW-1:0] cnt_dbg
);

  localparam logic [CW-1:0] WIN_C = CW'(WIN);
  localparam logic [CW-1:0] HI_C  = CW'(HI);
  localparam logic [CW-1:0] LO_C  = CW'(LO);

  logic [WIN-1:0] r_hist [CH];
  logic [CW-1:0]  r_cnt  [CH];
  logic [CW-1:0]  r_fill;
  logic [CH-1:0]  r_out;
  logic           r_out_valid;

  logic [WIN:0]   w_ext      [CH];
  logic [WIN-1:0] w_hist_nxt [CH];
  logic [CW-1:0]  w_cnt_nxt  [CH];
  logic [CH-1:0]  w_old;
  logic [CH-1:0]  w_out_nxt;
  logic [CW-1:0]  w_fill_nxt;
  logic           w_full;
  logic [CH*CW-1:0] w_cnt_dbg;

  always_comb begin
    w_fill_nxt = (r_fill == WIN_C) ? WIN_C : r_fill + CW'(1);
    w_full     = (w_fill_nxt == WIN_C);
    w_old      = '0;
    w_out_nxt  = r_out;
    w_cnt_dbg  = '0;
    for (int c = 0; c < CH; c++) begin
      // Before the window is full the leaving slot holds no real sample.
      w_old[c] = (r_fill == WIN_C) ? r_hist[c][WIN-1] : 1'b0;
      w_ext[c] = {r_hist[c], inp[c]};
      w_hist_nxt[c] = w_ext[c][WIN-1:0];
      w_cnt_nxt[c] = r_cnt[c] + CW'(inp[c]) - CW'(w_old[c]);
      if (!w_full)
        w_out_nxt[c] = 1'b0;
      else if (w_cnt_nxt[c] >= HI_C)
        w_out_nxt[c] = 1'b1;
      else if (w_cnt_nxt[c] <= LO_C)
        w_out_nxt[c] = 1'b0;
      w_cnt_dbg[c*CW +: CW] = r_cnt[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int c = 0; c < CH; c++) begin
        r_hist[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_fill      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      for (int c = 0; c < CH; c++) begin
        r_hist[c] <= w_hist_nxt[c];
        r_cnt[c]  <= w_cnt_nxt[c];
      end
      r_fill      <= w_fill_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= r_out_valid | w_full;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign cnt_dbg   = w_cnt_dbg;

endmodule
